mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, cell-memory word address width (256 words).
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL have parameter LOCK_MAX, default 15, maximum consecutive cycles a lock may be held.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have, per requester x in {0,1} (0 = evaluator core, 1 = loader/debug), these ports: req_x in 1 (access request); we_x in 1 (1 = write); lock_x in 1 (hold ownership across a multi-word cell access); addr_x in ADDR_W; wdata_x in DATA_W.
REQ-007 SHALL have, per requester x, these output ports: gnt_x out 1 (request accepted this cycle); rvalid_x out 1 (read data valid); rdata_x out DATA_W (read data).
REQ-008 SHALL have memory-side ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W and mem_rdata in DATA_W; the memory has one-cycle read latency.
REQ-009 SHALL have port lock_err  out  1  one-cycle pulse when a lock is forcibly released.

Function
REQ-010 SHALL accept at most one access per cycle; gnt_x is combinational from the state registers and req inputs, and the access is performed in the same cycle gnt_x is asserted.
REQ-011 SHALL drive mem_en=1 and forward we/addr/wdata of the granted requester in the grant cycle; with no grant, mem_en=0, mem_we=0, and mem_addr/mem_wdata=0.
REQ-012 SHALL assert rvalid_x exactly one cycle after a granted read (we_x=0) by x, with rdata_x=mem_rdata in that cycle; rdata_x SHALL be 0 whenever rvalid_x=0.
REQ-013 SHALL never assert rvalid for a granted write.
REQ-014 SHALL implement states IDLE, OWN0 and OWN1.
REQ-015 In IDLE, the arbiter SHALL grant the single requester if only one requests; if both request, it SHALL resolve per REQ-026/027.
REQ-016 In OWNx, the arbiter SHALL grant only x (when req_x=1); the other requester SHALL wait with gnt=0.
REQ-017 Transitions: IDLE->OWNx when x is granted with lock_x=1; OWNx->OWNx while lock_x=1; OWNx->IDLE in the cycle lock_x is sampled 0, with arbitration that cycle still restricted to x.
REQ-018 A lock cycle counter SHALL count cycles spent in OWNx; if it reaches LOCK_MAX, the next state SHALL be IDLE regardless of lock_x, and lock_err SHALL pulse for one cycle.
REQ-019 After a forced release, lock_x SHALL be ignored until it has been sampled 0 at least once; x then arbitrates as if unlocked.
REQ-020 The counter SHALL clear on entry to IDLE; the 4-bit counter width SHALL cover LOCK_MAX up to 15 without wrap.
REQ-021 lock_x asserted without req_x while in IDLE SHALL have no effect.
REQ-022 A requester that holds req_x=1 SHALL keep its inputs stable until gnt_x; the arbiter does not store pending requests.

Reset
REQ-023 While rst=1, the arbiter SHALL hold state=IDLE, lock counter=0, last_grant=1, both force-release flags=0, and lock_err=0.
REQ-024 While rst=1, all gnt, rvalid, rdata, and mem_* outputs SHALL be 0.
REQ-025 A read granted in the cycle before rst SHALL NOT produce rvalid after reset; reset mid-lock SHALL release ownership.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: on contention in IDLE, the arbiter SHALL grant the requester other than last_grant; last_grant SHALL update on every grant.
REQ-027 Macro MEM_ARB_RR_EN undefined: requester 0 SHALL always win contention in IDLE, and the last_grant register SHALL be absent.

Verification
REQ-028 Only req_0 (read, addr 0x03, mem holds 0xDEAD) -> gnt_0 in cycle 0; rvalid_0=1 and rdata_0=0xDEAD in cycle 1; rvalid_1=0.
REQ-029 Both requesters issue reads every cycle, without macro -> port 0 granted every cycle and gnt_1 never asserted; with MEM_ARB_RR_EN -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-030 req_0 with lock_0=1 for 3 reads (addrs 0x0D, 0x0E, 0x0F) while req_1 is held -> gnt_1=0 for those 3 cycles; gnt_1=1 in the first cycle after lock_0 drops to 0.
REQ-031 lock_1 held at 1 for 20 cycles -> lock_err pulses once after 15 cycles in OWN1; gnt_0 is granted on the next req_0; lock_1 is ignored until it is released.
REQ-032 Write by port 1 (addr 0x12, data 0x0008), then a read by port 0 of 0x12 -> mem_we=1 in the write cycle with no rvalid; rdata_0=0x0008.
REQ-033 rst asserted in the cycle after a granted read -> rvalid_0 stays 0; all outputs are 0; the state is IDLE after rst deasserts.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port cell memory (1-cycle read latency),
// with lock-based ownership and a forced-release watchdog. Define MEM_ARB_RR_EN for round-robin contention.
module mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0: evaluator core
  input  logic              req_0,
  input  logic              we_0,
  input  logic              lock_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  output logic [DATA_W-1:0] rdata_0,
  // requester 1: loader / debug
  input  logic              req_1,
  input  logic              we_1,
  input  logic              lock_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_1,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lock_err,
  // FSM observation: 0 = IDLE, 1 = OWN0, 2 = OWN1
  output logic [1:0]        dbg_state
);

  // Handshake: req_x/gnt_x is a valid/ready pair. A request is accepted (and the
  // memory access performed) in the cycle gnt_x is high; until then the requester
  // holds req/we/lock/addr/wdata stable. Nothing is queued inside the arbiter.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(LOCK_MAX - 1);

  state_t     state;
  logic [3:0] lock_cnt;
  logic       frc_0;
  logic       frc_1;
  logic       rv_0;
  logic       rv_1;
  logic       err_q;
  logic       pick_1;

`ifdef MEM_ARB_RR_EN
  logic       last_grant;
`endif

  // Contention winner in IDLE
  always_comb begin
    pick_1 = 1'b0;
`ifdef MEM_ARB_RR_EN
    pick_1 = ~last_grant;
`endif
  end

  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req_0 && req_1) begin
            gnt_0 = ~pick_1;
            gnt_1 = pick_1;
          end else begin
            gnt_0 = req_0;
            gnt_1 = req_1;
          end
        end
        OWN0:    gnt_0 = req_0;
        OWN1:    gnt_1 = req_1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_0) begin
      mem_en    = 1'b1;
      mem_we    = we_0;
      mem_addr  = addr_0;
      mem_wdata = wdata_0;
    end else if (gnt_1) begin
      mem_en    = 1'b1;
      mem_we    = we_1;
      mem_addr  = addr_1;
      mem_wdata = wdata_1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_cnt <= 4'd0;
      frc_0    <= 1'b0;
      frc_1    <= 1'b0;
      rv_0     <= 1'b0;
      rv_1     <= 1'b0;
      err_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      rv_0  <= gnt_0 & ~we_0;
      rv_1  <= gnt_1 & ~we_1;
      err_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      if (gnt_0) last_grant <= 1'b0;
      else if (gnt_1) last_grant <= 1'b1;
`endif
      // A force-release flag lasts until its lock input is seen low once
      if (!lock_0) frc_0 <= 1'b0;
      if (!lock_1) frc_1 <= 1'b0;

      case (state)
        IDLE: begin
          lock_cnt <= 4'd0;
          if (gnt_0 && lock_0 && !frc_0) state <= OWN0;
          else if (gnt_1 && lock_1 && !frc_1) state <= OWN1;
        end
        OWN0: begin
          if (lock_cnt == CNT_LAST) begin
            state    <= IDLE;
            lock_cnt <= 4'd0;
            err_q    <= 1'b1;
            frc_0    <= lock_0;
          end else if (!lock_0) begin
            state    <= IDLE;
            lock_cnt <= 4'd0;
          end else begin
            lock_cnt <= lock_cnt + 4'd1;
          end
        end
        OWN1: begin
          if (lock_cnt == CNT_LAST) begin
            state    <= IDLE;
            lock_cnt <= 4'd0;
            err_q    <= 1'b1;
            frc_1    <= lock_1;
          end else if (!lock_1) begin
            state    <= IDLE;
            lock_cnt <= 4'd0;
          end else begin
            lock_cnt <= lock_cnt + 4'd1;
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Registered outputs are masked during reset so a read launched just before
  // reset cannot surface while rst is high.
  assign rvalid_0  = rv_0 & ~rst;
  assign rvalid_1  = rv_1 & ~rst;
  assign rdata_0   = rvalid_0 ? mem_rdata : '0;
  assign rdata_1   = rvalid_1 ? mem_rdata : '0;
  assign lock_err  = err_q & ~rst;
  assign dbg_state = rst ? IDLE : state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: behavioural RAM, owner/lock reference model,
// per-port expected read-data queues, directed scenarios, one summary line.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LOCK_MAX = 15;

  logic clk;
  logic rst;
  logic req_0, we_0, lock_0, req_1, we_1, lock_1;
  logic [AW-1:0] addr_0, addr_1;
  logic [DW-1:0] wdata_0, wdata_1;
  logic gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [DW-1:0] rdata_0, rdata_1;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic lock_err;
  logic [1:0] dbg_state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .we_0(we_0), .lock_0(lock_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
    .req_1(req_1), .we_1(we_1), .lock_1(lock_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lock_err(lock_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural single-port RAM ----------------
  logic [DW-1:0] ram [0:255];
  logic ram_init;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 3) return 16'hDEAD;
    return 16'(i * 40503 + 7);
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass = 0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] mmem [0:255];
  int   own;          // -1 = nobody owns the memory
  int   held;         // cycles spent owned so far
  logic [1:0] blk;    // lock ignored after a forced release
  logic lastg;
  logic exp_rv0, exp_rv1, exp_err;
  logic hold0, hold1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    own = -1; held = 0; blk = 2'b00; lastg = 1'b1;
    exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_err = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    hold0 = 1'b0; hold1 = 1'b0;
  endtask

  // ---------------- driver: one clock cycle, checked against the model ----------------
  task automatic step(input logic rs,
                      input logic r0, input logic w0, input logic l0,
                      input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic r1, input logic w1, input logic l1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic pg0, pg1, win1, lo;
    logic [DW-1:0] e0, e1;
    logic [1:0] nb;
    logic [1:0] es;
    @(posedge clk); #1;
    rst = rs;
    req_0 = r0; we_0 = w0; lock_0 = l0; addr_0 = a0; wdata_0 = d0;
    req_1 = r1; we_1 = w1; lock_1 = l1; addr_1 = a1; wdata_1 = d1;
    @(negedge clk);
    if (rs) begin
      check("rst_gnt0", gnt_0, 0);      check("rst_gnt1", gnt_1, 0);
      check("rst_rv0", rvalid_0, 0);    check("rst_rv1", rvalid_1, 0);
      check("rst_rd0", rdata_0, 0);     check("rst_rd1", rdata_1, 0);
      check("rst_en", mem_en, 0);       check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);   check("rst_wdata", mem_wdata, 0);
      check("rst_err", lock_err, 0);    check("rst_state", dbg_state, 0);
      model_reset();
    end else begin
      win1 = 1'b0;
`ifdef MEM_ARB_RR_EN
      win1 = (lastg == 1'b0);
`endif
      if (own == 0)      begin pg0 = r0; pg1 = 1'b0; end
      else if (own == 1) begin pg0 = 1'b0; pg1 = r1; end
      else if (r0 && r1) begin pg0 = !win1; pg1 = win1; end
      else               begin pg0 = r0; pg1 = r1; end

      e0 = '0; e1 = '0;
      if (exp_rv0 && exp_q0.size() > 0) e0 = exp_q0.pop_front();
      if (exp_rv1 && exp_q1.size() > 0) e1 = exp_q1.pop_front();
      es = (own < 0) ? 2'd0 : (own == 0) ? 2'd1 : 2'd2;

      check("gnt0", gnt_0, pg0);
      check("gnt1", gnt_1, pg1);
      check("mem_en", mem_en, pg0 | pg1);
      check("mem_we", mem_we, pg0 ? w0 : pg1 ? w1 : 1'b0);
      check("mem_addr", mem_addr, pg0 ? a0 : pg1 ? a1 : '0);
      check("mem_wdata", mem_wdata, pg0 ? d0 : pg1 ? d1 : '0);
      check("rvalid0", rvalid_0, exp_rv0);
      check("rvalid1", rvalid_1, exp_rv1);
      check("rdata0", rdata_0, e0);
      check("rdata1", rdata_1, e1);
      check("lock_err", lock_err, exp_err);
      check("state", dbg_state, es);

      // advance the model across the coming clock edge
`ifdef MEM_ARB_RR_EN
      if (pg0) lastg = 1'b0;
      if (pg1) lastg = 1'b1;
`endif
      exp_rv0 = pg0 && !w0;
      exp_rv1 = pg1 && !w1;
      if (exp_rv0) exp_q0.push_back(mmem[a0]);
      if (exp_rv1) exp_q1.push_back(mmem[a1]);
      if (pg0 && w0) mmem[a0] = d0;
      if (pg1 && w1) mmem[a1] = d1;

      nb = blk;
      if (!l0) nb[0] = 1'b0;
      if (!l1) nb[1] = 1'b0;
      exp_err = 1'b0;
      if (own >= 0) begin
        lo = (own == 0) ? l0 : l1;
        held++;
        if (held == LOCK_MAX) begin
          exp_err = 1'b1;
          nb[own] = lo;
          own = -1;
        end else if (!lo) begin
          own = -1;
        end
      end else if (pg0 && l0 && !blk[0]) begin
        own = 0; held = 0;
      end else if (pg1 && l1 && !blk[1]) begin
        own = 1; held = 0;
      end
      blk = nb;
      hold0 = r0 && !pg0;
      hold1 = r1 && !pg1;
    end
  endtask

  task automatic idle_cyc();
    step(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  logic cr0, cw0, cl0, cr1, cw1, cl1;
  logic [AW-1:0] ca0, ca1;
  logic [DW-1:0] cd0, cd1;
  int burst0, burst1, err_cnt;
  logic exp_g0;

  initial begin
    rst = 1'b1; ram_init = 1'b1;
    req_0 = 0; we_0 = 0; lock_0 = 0; addr_0 = '0; wdata_0 = '0;
    req_1 = 0; we_1 = 0; lock_1 = 0; addr_1 = '0; wdata_1 = '0;
    for (int i = 0; i < 256; i++) mmem[i] = init_word(i);
    model_reset();

    step(1, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    ram_init = 1'b0;
    step(1, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    idle_cyc();

    // single read by port 0 of 0x03
    step(0, 1, 0, 0, 8'h03, '0, 0, 0, 0, '0, '0);
    check("d_rd_gnt0", gnt_0, 1);
    idle_cyc();
    check("d_rd_rv0", rvalid_0, 1);
    check("d_rd_data", rdata_0, 16'hDEAD);
    check("d_rd_rv1", rvalid_1, 0);

    // both ports read every cycle, starting from reset
    step(1, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 8'h05, '0, 1, 0, 0, 8'h06, '0);
`ifdef MEM_ARB_RR_EN
      exp_g0 = (i % 2 == 0);
`else
      exp_g0 = 1'b1;
`endif
      check("d_cont_gnt0", gnt_0, exp_g0);
      check("d_cont_gnt1", gnt_1, !exp_g0);
    end
    idle_cyc();
    idle_cyc();

    // port 0 locks for three reads while port 1 waits
    step(0, 1, 0, 1, 8'h0D, '0, 0, 0, 0, '0, '0);
    check("d_lk_gnt1_a", gnt_1, 0);
    step(0, 1, 0, 1, 8'h0E, '0, 1, 0, 0, 8'h40, '0);
    check("d_lk_gnt1_b", gnt_1, 0);
    step(0, 1, 0, 1, 8'h0F, '0, 1, 0, 0, 8'h40, '0);
    check("d_lk_gnt1_c", gnt_1, 0);
    step(0, 0, 0, 0, '0, '0, 1, 0, 0, 8'h40, '0);
    check("d_lk_drop_gnt1", gnt_1, 0);
    step(0, 0, 0, 0, '0, '0, 1, 0, 0, 8'h40, '0);
    check("d_lk_after_gnt1", gnt_1, 1);
    idle_cyc();
    idle_cyc();

    // port 1 holds lock past the limit
    err_cnt = 0;
    for (int i = 1; i <= 24; i++) begin
      if (i <= 20)
        step(0, (i >= 2 && i <= 17), 0, 0, 8'h21, '0, 1, 0, 1, 8'h22, '0);
      else if (i == 21 || i == 23 || i == 24)
        step(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
      else
        step(0, 0, 0, 0, '0, '0, 1, 0, 1, 8'h23, '0);
      if (lock_err) err_cnt++;
      if (i == 17) begin
        check("d_force_err", lock_err, 1);
        check("d_force_gnt0", gnt_0, 1);
      end
      if (i >= 18 && i <= 20) begin
        check("d_ign_state", dbg_state, 0);
        check("d_ign_gnt1", gnt_1, 1);
      end
      if (i == 23) check("d_relock_state", dbg_state, 2);
    end
    check("d_err_pulses", err_cnt, 1);

    // write by port 1 then read back by port 0
    step(0, 0, 0, 0, '0, '0, 1, 1, 0, 8'h12, 16'h0008);
    check("d_wr_we", mem_we, 1);
    check("d_wr_addr", mem_addr, 8'h12);
    check("d_wr_data", mem_wdata, 16'h0008);
    step(0, 1, 0, 0, 8'h12, '0, 0, 0, 0, '0, '0);
    check("d_wr_norv1", rvalid_1, 0);
    idle_cyc();
    check("d_wr_rv0", rvalid_0, 1);
    check("d_wr_rd0", rdata_0, 16'h0008);

    // reset right after a granted read
    step(0, 1, 0, 0, 8'h03, '0, 0, 0, 0, '0, '0);
    step(1, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    check("d_rst_rv0", rvalid_0, 0);
    idle_cyc();
    check("d_rst_rv0_after", rvalid_0, 0);
    check("d_rst_state", dbg_state, 0);

    // randomized traffic
    burst0 = 0; burst1 = 0;
    cr0 = 0; cw0 = 0; cl0 = 0; ca0 = '0; cd0 = '0;
    cr1 = 0; cw1 = 0; cl1 = 0; ca1 = '0; cd1 = '0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        step(1, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        continue;
      end
      if (!hold0) begin
        cr0 = ($urandom_range(0, 99) < 55);
        cw0 = ($urandom_range(0, 2) == 0);
        ca0 = 8'($urandom_range(0, 31));
        cd0 = 16'($urandom);
        if (burst0 > 0) begin cl0 = 1'b1; burst0--; end
        else begin
          cl0 = 1'b0;
          if ($urandom_range(0, 9) == 0) burst0 = $urandom_range(1, 20);
        end
      end
      if (!hold1) begin
        cr1 = ($urandom_range(0, 99) < 55);
        cw1 = ($urandom_range(0, 2) == 0);
        ca1 = 8'($urandom_range(0, 31));
        cd1 = 16'($urandom);
        if (burst1 > 0) begin cl1 = 1'b1; burst1--; end
        else begin
          cl1 = 1'b0;
          if ($urandom_range(0, 9) == 0) burst1 = $urandom_range(1, 20);
        end
      end
      step(0, cr0, cw0, cl0, ca0, cd0, cr1, cw1, cl1, ca1, cd1);
    end
    idle_cyc();
    idle_cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
